// File: rtl/c64_bus_ctrl.sv
// c64_bus_ctrl: 6510 port, C64 banking/chip-select decode and VIC DMA arbitration.
module c64_bus_ctrl #(
  parameter int STALL_CYCLES = 3,
  parameter int PORT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_ab,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_we,
  output logic [7:0]        cpu_di,
  output logic              cpu_rdy,
  output logic [15:0]       mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              basic_cs,
  output logic              kernal_cs,
  output logic              char_cs,
  output logic              io_cs,
  output logic              io_we,
  input  logic [7:0]        ram_rd,
  input  logic [7:0]        basic_rd,
  input  logic [7:0]        kernal_rd,
  input  logic [7:0]        char_rd,
  input  logic [7:0]        io_rd,
  input  logic [PORT_W-1:0] port_in,
  output logic [PORT_W-1:0] port_out,
  output logic [PORT_W-1:0] port_ddr,
  input  logic              dma_req,
  output logic              dma_ack
);
  localparam int CW = $clog2(STALL_CYCLES + 1);
  typedef enum logic [2:0] {RG_RAM, RG_BASIC, RG_KERNAL, RG_CHAR, RG_IO, RG_PORT0, RG_PORT1} region_e;
  typedef enum logic [2:0] {RUN, WAIT_WR, STALL, GRANT, RELEASE} state_e;
  state_e            state_q;
  region_e           region_q, region_d;
  logic [CW-1:0]     cnt_q;
  logic              rdy_q, ack_q, vld_q;
  logic [PORT_W-1:0] ddr_q, ddr_d, pdata_q, pdata_d, port_rd;
  logic              loram, hiram, charen, in_d, io_vis, io_wr, bus_en, port_wr;
  always_comb begin
    loram   = ~ddr_q[0] | pdata_q[0];
    hiram   = ~ddr_q[1] | pdata_q[1];
    charen  = ~ddr_q[2] | pdata_q[2];
    in_d    = cpu_ab[15:12] == 4'hD;
    io_vis  = (loram | hiram) & charen;
    io_wr   = in_d & io_vis;
    bus_en  = ~ack_q;
    port_wr = bus_en & cpu_we & (cpu_ab[15:1] == 15'd0);
    region_d = cpu_ab == 16'h0000 ? RG_PORT0 :
               cpu_ab == 16'h0001 ? RG_PORT1 :
               (cpu_ab[15:13] == 3'b101 && loram && hiram) ? RG_BASIC :
               io_wr ? RG_IO :
               (in_d && (loram || hiram)) ? RG_CHAR :
               (cpu_ab[15:13] == 3'b111 && hiram) ? RG_KERNAL : RG_RAM;
    ddr_d   = (port_wr && !cpu_ab[0]) ? PORT_W'(cpu_do) : ddr_q;
    pdata_d = (port_wr && cpu_ab[0]) ? PORT_W'(cpu_do) : pdata_q;
    port_rd = (pdata_q & ddr_q) | (port_in & ~ddr_q);
  end
  assign mem_addr  = cpu_ab;
  assign mem_wdata = cpu_do;
  assign ram_cs    = bus_en & (cpu_we ? ~io_wr : region_d == RG_RAM);
  assign ram_we    = bus_en & cpu_we & ~io_wr;
  assign io_cs     = bus_en & (cpu_we ? io_wr : region_d == RG_IO);
  assign io_we     = bus_en & cpu_we & io_wr;
  assign basic_cs  = bus_en & ~cpu_we & (region_d == RG_BASIC);
  assign kernal_cs = bus_en & ~cpu_we & (region_d == RG_KERNAL);
  assign char_cs   = bus_en & ~cpu_we & (region_d == RG_CHAR);
  assign port_out  = pdata_q & ddr_q;
  assign port_ddr  = ddr_q;
  assign cpu_rdy   = rdy_q;
  assign dma_ack   = ack_q;
  // vld_q keeps cpu_di at zero until the first address has been sampled out of reset
  assign cpu_di = !vld_q ? 8'h00 :
                  region_q == RG_BASIC  ? basic_rd :
                  region_q == RG_KERNAL ? kernal_rd :
                  region_q == RG_CHAR   ? char_rd :
                  region_q == RG_IO     ? io_rd :
                  region_q == RG_PORT0  ? 8'(ddr_q) :
                  region_q == RG_PORT1  ? 8'(port_rd) : ram_rd;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ddr_q    <= '0;
      pdata_q  <= '0;
      region_q <= RG_RAM;
      vld_q    <= 1'b0;
    end else begin
      ddr_q    <= ddr_d;
      pdata_q  <= pdata_d;
      region_q <= region_d;
      vld_q    <= 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN, WAIT_WR:
          if (!dma_req) begin
            state_q <= RUN;
            rdy_q   <= 1'b1;
          end else if (!cpu_we) begin
            state_q <= STALL;
            cnt_q   <= CW'(1);
            rdy_q   <= 1'b0;
          end else
            state_q <= WAIT_WR;
        STALL:
          if (!dma_req) begin
            state_q <= RUN;
            rdy_q   <= 1'b1;
          end else if (cnt_q == CW'(STALL_CYCLES)) begin
            state_q <= GRANT;
            ack_q   <= 1'b1;
          end else
            cnt_q <= cnt_q + CW'(1);
        GRANT:
          if (!dma_req) begin
            state_q <= RELEASE;
            ack_q   <= 1'b0;
          end
        default: begin
          state_q <= RUN;
          rdy_q   <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_c64_bus_ctrl.sv
// tb_c64_bus_ctrl: directed checks of banking, decode, port and DMA stall/grant.
module tb_c64_bus_ctrl;
  logic        clk = 0, reset = 1;
  logic [15:0] cpu_ab = 16'h0002, mem_addr;
  logic [7:0]  cpu_do = 0, cpu_di, mem_wdata;
  logic        cpu_we = 0, cpu_rdy, dma_req = 0, dma_ack;
  logic        ram_cs, ram_we, basic_cs, kernal_cs, char_cs, io_cs, io_we;
  logic [7:0]  ram_rd = 8'h11, basic_rd = 8'h22, kernal_rd = 8'h85, char_rd = 8'h3C, io_rd = 8'h77;
  logic [7:0]  port_in = 8'h3F, port_out, port_ddr;
  int          pass = 0, total = 0;

  c64_bus_ctrl dut (
    .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .basic_cs(basic_cs), .kernal_cs(kernal_cs),
    .char_cs(char_cs), .io_cs(io_cs), .io_we(io_we), .ram_rd(ram_rd), .basic_rd(basic_rd),
    .kernal_rd(kernal_rd), .char_rd(char_rd), .io_rd(io_rd), .port_in(port_in),
    .port_out(port_out), .port_ddr(port_ddr), .dma_req(dma_req), .dma_ack(dma_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [15:0] ab, input logic [7:0] d);
    cpu_we = we;
    cpu_ab = ab;
    cpu_do = d;
    #1;
  endtask

  initial begin
    #12;
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_ack", dma_ack, 0);
    chk("rst_di", cpu_di, 0);
    chk("rst_ddr", port_ddr, 0);
    chk("rst_pout", port_out, 0);
    tick();
    reset = 0;
    drive(0, 16'hE000, 0);
    chk("kern_cs", kernal_cs, 1);
    chk("kern_ramcs", ram_cs, 0);
    chk("maddr", mem_addr, 16'hE000);
    tick();
    chk("kern_di", cpu_di, 8'h85);
    drive(0, 16'h0001, 0);
    tick();
    chk("p1_rd_rst", cpu_di, 8'h3F);
    drive(1, 16'h0000, 8'h07);
    chk("ddr_wr_ramwe", ram_we, 1);
    chk("wdata", mem_wdata, 8'h07);
    tick();
    chk("ddr", port_ddr, 8'h07);
    drive(1, 16'h0001, 8'h05);
    tick();
    chk("pout5", port_out, 8'h05);
    drive(0, 16'hE000, 0);
    chk("hi0_ramcs", ram_cs, 1);
    chk("hi0_kerncs", kernal_cs, 0);
    tick();
    chk("hi0_di", cpu_di, 8'h11);
    drive(0, 16'hD020, 0);
    chk("io_cs", io_cs, 1);
    tick();
    chk("io_di", cpu_di, 8'h77);
    drive(0, 16'hA000, 0);
    chk("hi0_basic", basic_cs, 0);
    drive(1, 16'h0001, 8'h03);
    tick();
    drive(0, 16'hD000, 0);
    chk("char_cs", char_cs, 1);
    chk("char_iocs", io_cs, 0);
    tick();
    chk("char_di", cpu_di, 8'h3C);
    drive(1, 16'hD000, 8'hAA);
    chk("chw_ramwe", ram_we, 1);
    chk("chw_iowe", io_we, 0);
    chk("chw_charcs", char_cs, 0);
    drive(1, 16'h0001, 8'h07);
    tick();
    drive(1, 16'hA000, 8'h55);
    chk("bw_ramwe", ram_we, 1);
    chk("bw_basic", basic_cs, 0);
    drive(1, 16'hD400, 8'h01);
    chk("iow_ramcs", ram_cs, 0);
    chk("iow_iowe", io_we, 1);
    drive(0, 16'hA000, 0);
    chk("basic_cs", basic_cs, 1);
    tick();
    chk("basic_di", cpu_di, 8'h22);
    port_in = 8'hC0;
    drive(0, 16'h0001, 0);
    tick();
    chk("p1_rd_mix", cpu_di, 8'hC7);
    drive(0, 16'h0000, 0);
    tick();
    chk("p0_rd", cpu_di, 8'h07);
    drive(0, 16'h1000, 0);
    dma_req = 1;
    chk("dma_rdy_pre", cpu_rdy, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("stall%0d_rdy", i), cpu_rdy, 0);
      chk($sformatf("stall%0d_ack", i), dma_ack, 0);
    end
    tick();
    chk("grant_ack", dma_ack, 1);
    chk("grant_rdy", cpu_rdy, 0);
    drive(1, 16'h0001, 8'h00);
    chk("grant_ramcs", ram_cs, 0);
    chk("grant_ramwe", ram_we, 0);
    tick();
    chk("grant_nowr", port_out, 8'h07);
    drive(0, 16'h1000, 0);
    dma_req = 0;
    tick();
    chk("rel_ack", dma_ack, 0);
    chk("rel_rdy", cpu_rdy, 0);
    tick();
    chk("run_rdy", cpu_rdy, 1);
    drive(1, 16'h0000, 8'h0F);
    dma_req = 1;
    tick();
    chk("ww_ddr", port_ddr, 8'h0F);
    chk("ww_rdy1", cpu_rdy, 1);
    tick();
    chk("ww_rdy2", cpu_rdy, 1);
    drive(0, 16'h1000, 0);
    tick();
    chk("ww_stall", cpu_rdy, 0);
    tick();
    tick();
    tick();
    chk("ww_grant", dma_ack, 1);
    #2;
    reset = 1;
    #1;
    chk("rstg_ack", dma_ack, 0);
    chk("rstg_rdy", cpu_rdy, 1);
    chk("rstg_ddr", port_ddr, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
